rr_arb_bin: RTL and testbench
=============================

# rr_arb_bin

- Round-robin arbiter over `NUM_REQ` request lines.
- Emits the winning requester as a registered binary index with a valid/ready handshake.
- Sits directly upstream of `binto_onehot`: `gnt_bin_o` drives its `bin_i`, and the decoded one-hot output becomes the per-requester grant vector.
- Rotating priority gives every persistent requester a grant within `NUM_REQ` handshakes.

## Interface
- Clock `clk`, reset `reset`: one clock; reset is asynchronous and active-high.

Parameters:
- `NUM_REQ`, default 16: number of request lines; must satisfy 2 ≤ `NUM_REQ` ≤ 2**`BIN_W`.
- `BIN_W`, default 4: width of the binary grant index; matches `binto_onehot` `BIN_W`.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous active-high reset
- `req_i`  in  NUM_REQ  request vector; bit k = requester k wants service
- `gnt_ready_i`  in  1  downstream accepts current grant this cycle
- `gnt_valid_o`  out  1  `gnt_bin_o` holds a valid grant
- `gnt_bin_o`  out  BIN_W  index of granted requester
- `gnt_count_o`  out  8  completed-handshake counter; present only with `RR_ARB_GNT_COUNT_EN`

## Operation
**State and reset**
- States: IDLE (`gnt_valid_o`=0) and GRANT (`gnt_valid_o`=1).
- Priority pointer `ptr` (BIN_W bits) names the highest-priority requester.
- Reset values: state IDLE, `ptr`=0, `gnt_valid_o`=0, `gnt_bin_o`=0, `gnt_count_o`=0.

**Arbitration function**
- Winner = first k with `req_i[k]`=1, scanning circularly `ptr`, `ptr+1`, …, `NUM_REQ-1`, 0, …, `ptr-1`.
- Request bits at index ≥ `NUM_REQ` do not exist.
- Index arithmetic is mod `NUM_REQ`, not mod 2**`BIN_W`.

**IDLE**
- `req_i` == 0: stay IDLE.
- Otherwise: register winner into `gnt_bin_o` and go to GRANT.

**GRANT**
- `gnt_bin_o` and `gnt_valid_o` stay stable until the handshake (`gnt_valid_o` & `gnt_ready_i`), even if `req_i` changes or the granted bit drops.
- Handshake updates `ptr` to (`gnt_bin_o`+1) mod `NUM_REQ`; `NUM_REQ-1` wraps to 0.
- On the handshake cycle, the arbitration function re-evaluates with the new pointer and current `req_i`:
  - If some request is set: stay GRANT, load new winner (back-to-back, no bubble).
  - Else: go to IDLE.
- A requester granted on a handshake may win again immediately only if it is the sole requester.

**Reset**
- Reset mid-GRANT drops `gnt_valid_o` asynchronously; the pending grant is discarded.

## Timing
- Latency: `req_i` asserted in IDLE at edge N gives `gnt_valid_o`=1 after edge N+1 (one registered cycle).
- Throughput: one grant per cycle while `gnt_ready_i`=1 and requests persist.
- `gnt_ready_i` in IDLE is ignored; no state change.
- All outputs are registered; none combinational from inputs.
- Worst-case wait for a continuously asserted request: `NUM_REQ`-1 handshakes.

## Configuration
- Macro: `RR_ARB_GNT_COUNT_EN`.
- Defined:
  - `gnt_count_o` port exists.
  - 8-bit counter increments on each handshake and saturates at 255; no wrap.
  - Reset to 0.
- Undefined:
  - Port and counter are absent.
  - Arbitration behaviour is identical.

## Test plan
- Reset then `req_i`=16'h0000 for 10 cycles, `gnt_ready_i`=1 -> `gnt_valid_o` stays 0, `gnt_bin_o`=0.
- `req_i`=16'hFFFF, `gnt_ready_i`=1 for 17 cycles -> `gnt_bin_o` sequence 0,1,…,15,0 on consecutive cycles with no gaps.
- `req_i`=16'h0024 (bits 2,5), `ptr`=0, `gnt_ready_i`=1 -> grants 2,5,2,5…; after grant 5 the pointer wraps to 6 and next grant is 2.
- Grant index 3 pending with `gnt_ready_i`=0 for 5 cycles, `req_i` changed to 16'h0100 meanwhile -> `gnt_bin_o` holds 3 with valid=1; when ready=1, next grant is 8.
- `reset` asserted asynchronously mid-GRANT, between edges -> `gnt_valid_o` falls immediately; after release with `req_i`=16'h8001, first grant is 0.
- With `RR_ARB_GNT_COUNT_EN`: 300 back-to-back handshakes -> `gnt_count_o` reads 255 and stays there.

Source files
------------

// File: rtl/rr_arb_bin.sv
// rr_arb_bin: round-robin arbiter that registers the winning requester as a
// binary index with a valid/ready handshake. The priority pointer moves to one
// past each accepted grant, so every requester that keeps its request asserted
// is served within NUM_REQ handshakes.
// Ports: clk, reset (async, active-high), req_i[NUM_REQ], gnt_ready_i,
//        gnt_valid_o, gnt_bin_o[BIN_W], gnt_count_o[8] (when
//        RR_ARB_GNT_COUNT_EN is defined: saturating count of handshakes).
module rr_arb_bin #(
  parameter int NUM_REQ = 16,
  parameter int BIN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               gnt_ready_i,
  output logic               gnt_valid_o,
  output logic [BIN_W-1:0]   gnt_bin_o
`ifdef RR_ARB_GNT_COUNT_EN
  ,
  output logic [7:0]         gnt_count_o
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [BIN_W:0]   NUM_REQ_W = (BIN_W+1)'(NUM_REQ);
  localparam logic [BIN_W-1:0] LAST_IDX  = BIN_W'(NUM_REQ - 1);

  state_e           state_q, state_d;
  logic [BIN_W-1:0] ptr_q, ptr_d;
  logic [BIN_W-1:0] bin_q, bin_d;

  logic             hs;
  logic [BIN_W-1:0] inc_ptr;
  logic [BIN_W-1:0] arb_ptr;
  logic [BIN_W-1:0] win_idx;
  logic             win_found;
  logic [BIN_W:0]   cand;

  assign hs = (state_q == GRANT) & gnt_ready_i;

  // Wrap at NUM_REQ, not at 2**BIN_W.
  always_comb begin
    inc_ptr = bin_q + 1'b1;
    if (bin_q == LAST_IDX) begin
      inc_ptr = '0;
    end
  end

  // On a handshake the next winner is picked with the already-advanced pointer
  // so back-to-back grants rotate without a bubble.
  assign arb_ptr = hs ? inc_ptr : ptr_q;

  // Circular scan from arb_ptr; cand is kept one bit wider so the sum
  // can be reduced mod NUM_REQ before indexing.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, arb_ptr} + (BIN_W+1)'(i);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!win_found && req_i[cand[BIN_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[BIN_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bin_d   = bin_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          bin_d   = win_idx;
        end
      end
      GRANT: begin
        if (hs) begin
          ptr_d = inc_ptr;
          if (win_found) begin
            bin_d = win_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bin_q   <= bin_d;
    end
  end

  assign gnt_valid_o = (state_q == GRANT);
  assign gnt_bin_o   = bin_q;

`ifdef RR_ARB_GNT_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Saturates at 255 instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (hs && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign gnt_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb_bin.sv
// tb_rr_arb_bin: directed bench for rr_arb_bin with a rule-level model
// compared every cycle plus hand-computed literal expectations.
module tb_rr_arb_bin;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req_i = '0;
  logic         gnt_ready_i = 1'b0;
  logic         gnt_valid_o;
  logic [W-1:0] gnt_bin_o;
`ifdef RR_ARB_GNT_COUNT_EN
  logic [7:0]   gnt_count_o;
`endif

  int checks = 0;
  int errors = 0;

  rr_arb_bin #(.NUM_REQ(N), .BIN_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .gnt_ready_i (gnt_ready_i),
    .gnt_valid_o (gnt_valid_o),
    .gnt_bin_o   (gnt_bin_o)
`ifdef RR_ARB_GNT_COUNT_EN
    ,
    .gnt_count_o (gnt_count_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: first requester at or after ptr, wrapping modulo N.
  function automatic int winner(input int ptr, input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  int m_valid = 0;
  int m_bin   = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0;
      m_bin   = 0;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_valid == 1 && gnt_ready_i) begin
      m_ptr = (m_bin + 1) % N;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
      if (req_i != '0) m_bin = winner(m_ptr, req_i);
      else m_valid = 0;
    end else if (m_valid == 0 && req_i != '0) begin
      m_bin   = winner(m_ptr, req_i);
      m_valid = 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_valid", int'(gnt_valid_o), m_valid);
      if (m_valid == 1) chk("model_bin", int'(gnt_bin_o), m_bin);
`ifdef RR_ARB_GNT_COUNT_EN
      chk("model_count", int'(gnt_count_o), m_cnt);
`endif
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  logic [N-1:0] vec_req [8];
  logic         vec_rdy [8];

  initial begin
    // Idle with ready high: nothing happens.
    req_i = '0;
    gnt_ready_i = 1'b1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_valid", int'(gnt_valid_o), 0);
    end
    chk("idle_bin", int'(gnt_bin_o), 0);

    // All requesting: 0..15 then wrap to 0, no gaps.
    req_i = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      chk("all_valid", int'(gnt_valid_o), 1);
      chk("all_bin", int'(gnt_bin_o), k % 16);
    end
    req_i = '0;

    // Bits 2 and 5 alternate.
    do_reset();
    req_i = 16'h0024;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("alt_bin", int'(gnt_bin_o), (k % 2 == 0) ? 2 : 5);
    end
    req_i = '0;

    // Stalled grant 3 holds while requests change; then 8.
    do_reset();
    gnt_ready_i = 1'b0;
    req_i = 16'h0008;
    @(negedge clk);
    chk("hold_first", int'(gnt_bin_o), 3);
    req_i = 16'h0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", int'(gnt_valid_o), 1);
      chk("hold_bin", int'(gnt_bin_o), 3);
    end
    gnt_ready_i = 1'b1;
    @(negedge clk);
    chk("after_hold", int'(gnt_bin_o), 8);
    req_i = '0;
    @(negedge clk);
    chk("back_idle", int'(gnt_valid_o), 0);

    // Asynchronous reset between edges during a pending grant.
    gnt_ready_i = 1'b0;
    req_i = 16'hFFFF;
    @(negedge clk);
    chk("pre_rst_valid", int'(gnt_valid_o), 1);
    #2 reset = 1'b1;
    #1 chk("async_rst", int'(gnt_valid_o), 0);
    @(negedge clk);
    req_i = 16'h8001;
    gnt_ready_i = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_0", int'(gnt_bin_o), 0);
    @(negedge clk);
    chk("post_rst_15", int'(gnt_bin_o), 15);
    @(negedge clk);
    chk("post_rst_wrap", int'(gnt_bin_o), 0);

    // Mixed vectors with varying ready; model checks every cycle.
    vec_req = '{16'h0000, 16'h1010, 16'h1010, 16'h0001,
                16'h8000, 16'h00F0, 16'h00F0, 16'h0000};
    vec_rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_i = vec_req[k];
      gnt_ready_i = vec_rdy[k];
    end
    @(negedge clk);
    @(negedge clk);

`ifdef RR_ARB_GNT_COUNT_EN
    do_reset();
    req_i = 16'hFFFF;
    gnt_ready_i = 1'b1;
    repeat (301) @(negedge clk);
    chk("count_sat", int'(gnt_count_o), 255);
    repeat (5) @(negedge clk);
    chk("count_stay", int'(gnt_count_o), 255);
    req_i = '0;
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
